// File: rtl/cpu_types_pkg.sv
// Shared MIPS pipeline types: datapath words, register numbers, ALU encodings and
// the packed ID/EX register image.
package cpu_types_pkg;

   localparam int unsigned STALL_CNT_W = 16;

   typedef logic [31:0] word_t;
   typedef logic [4:0]  regbits_t;

   typedef enum logic [3:0] {
      ALU_SLL  = 4'b0000,
      ALU_SRL  = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_SUB  = 4'b0011,
      ALU_AND  = 4'b0100,
      ALU_OR   = 4'b0101,
      ALU_XOR  = 4'b0110,
      ALU_NOR  = 4'b0111,
      ALU_SLT  = 4'b1010,
      ALU_SLTU = 4'b1011
   } aluop_t;

   typedef struct packed {
      logic     valid;
      logic     regwen;
      logic     memren;
      logic     memwen;
      logic     alusrc;
      aluop_t   aluop;
      regbits_t rs;
      regbits_t rt;
      regbits_t wsel;
      word_t    rdat1;
      word_t    rdat2;
      word_t    imm;
      word_t    pc;
   } idex_t;

   // All-zero image doubles as the bubble: no control, aluop = ALU_SLL.
   localparam idex_t IDEX_BUBBLE = '0;

   // $zero never produces a dependency.
   function automatic logic reg_match(regbits_t a, regbits_t b);
      return (a == b) && (a != '0);
   endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID inputs, MEM/WB writer info, and EX-side outputs.
// master drives the ID/MEM/WB side, slave is the stage itself.
interface id_ex_stage_if
   import cpu_types_pkg::*;
();

   logic     enable;
   logic     flush;
   logic     id_valid;
   logic     id_regwen;
   logic     id_memren;
   logic     id_memwen;
   logic     id_alusrc;
   aluop_t   id_aluop;
   regbits_t id_rs;
   regbits_t id_rt;
   regbits_t id_wsel;
   word_t    id_rdat1;
   word_t    id_rdat2;
   word_t    id_imm;
   word_t    id_pc;
   logic     mem_regwen;
   logic     wb_regwen;
   regbits_t mem_wsel;
   regbits_t wb_wsel;
   word_t    mem_result;
   word_t    wb_result;

   logic                   hazard_stall;
   word_t                  ex_portA;
   word_t                  ex_portB;
   aluop_t                 ex_aluop;
   word_t                  ex_storedata;
   logic                   ex_valid;
   logic                   ex_regwen;
   logic                   ex_memren;
   logic                   ex_memwen;
   regbits_t               ex_wsel;
   word_t                  ex_pc;
   logic [STALL_CNT_W-1:0] stall_count;

   modport master (
      output enable, flush, id_valid, id_regwen, id_memren, id_memwen, id_alusrc, id_aluop,
             id_rs, id_rt, id_wsel, id_rdat1, id_rdat2, id_imm, id_pc,
             mem_regwen, wb_regwen, mem_wsel, wb_wsel, mem_result, wb_result,
      input  hazard_stall, ex_portA, ex_portB, ex_aluop, ex_storedata, ex_valid, ex_regwen,
             ex_memren, ex_memwen, ex_wsel, ex_pc, stall_count
   );

   modport slave (
      input  enable, flush, id_valid, id_regwen, id_memren, id_memwen, id_alusrc, id_aluop,
             id_rs, id_rt, id_wsel, id_rdat1, id_rdat2, id_imm, id_pc,
             mem_regwen, wb_regwen, mem_wsel, wb_wsel, mem_result, wb_result,
      output hazard_stall, ex_portA, ex_portB, ex_aluop, ex_storedata, ex_valid, ex_regwen,
             ex_memren, ex_memwen, ex_wsel, ex_pc, stall_count
   );

endinterface

// File: rtl/id_ex_stage_forward_unit.sv
// Operand bypass for one register number: MEM result beats WB result beats the
// value latched from the register file.
module forward_unit
   import cpu_types_pkg::*;
(
   input  regbits_t rnum,
   input  word_t    rdat,
   input  logic     mem_regwen,
   input  regbits_t mem_wsel,
   input  word_t    mem_result,
   input  logic     wb_regwen,
   input  regbits_t wb_wsel,
   input  word_t    wb_result,
   output word_t    fwd_data
);

   always_comb begin
      fwd_data = rdat;
      if (mem_regwen && reg_match(mem_wsel, rnum)) begin
         fwd_data = mem_result;
      end else if (wb_regwen && reg_match(wb_wsel, rnum)) begin
         fwd_data = wb_result;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion, hazard detection and operand bypass.
// Define FORWARD_EN for MEM/WB forwarding; otherwise any RAW on EX/MEM writers stalls.
module id_ex_stage
   import cpu_types_pkg::*;
(
   input logic          CLK,
   input logic          nRST,
   id_ex_stage_if.slave bus
);

   idex_t                  idex_q, idex_d, id_fields;
   logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
   logic                   hazard;
   logic                   load_use;
   logic                   rt_used;
   word_t                  fwd_rs, fwd_rt;

   assign id_fields = '{
      valid:  bus.id_valid,
      regwen: bus.id_regwen,
      memren: bus.id_memren,
      memwen: bus.id_memwen,
      alusrc: bus.id_alusrc,
      aluop:  bus.id_aluop,
      rs:     bus.id_rs,
      rt:     bus.id_rt,
      wsel:   bus.id_wsel,
      rdat1:  bus.id_rdat1,
      rdat2:  bus.id_rdat2,
      imm:    bus.id_imm,
      pc:     bus.id_pc
   };

   // rt is a true source unless it is only the I-type destination; sw reads it.
   assign rt_used  = ~bus.id_alusrc | bus.id_memwen;
   assign load_use = idex_q.valid & idex_q.memren & bus.id_valid &
                     (reg_match(idex_q.wsel, bus.id_rs) |
                      (reg_match(idex_q.wsel, bus.id_rt) & rt_used));

`ifdef FORWARD_EN
   assign hazard = load_use;

   forward_unit u_fwd_rs (
      .rnum       (idex_q.rs),
      .rdat       (idex_q.rdat1),
      .mem_regwen (bus.mem_regwen),
      .mem_wsel   (bus.mem_wsel),
      .mem_result (bus.mem_result),
      .wb_regwen  (bus.wb_regwen),
      .wb_wsel    (bus.wb_wsel),
      .wb_result  (bus.wb_result),
      .fwd_data   (fwd_rs)
   );

   forward_unit u_fwd_rt (
      .rnum       (idex_q.rt),
      .rdat       (idex_q.rdat2),
      .mem_regwen (bus.mem_regwen),
      .mem_wsel   (bus.mem_wsel),
      .mem_result (bus.mem_result),
      .wb_regwen  (bus.wb_regwen),
      .wb_wsel    (bus.wb_wsel),
      .wb_result  (bus.wb_result),
      .fwd_data   (fwd_rt)
   );
`else
   logic raw_ex, raw_mem, unused_fwd;

   assign raw_ex  = idex_q.valid & idex_q.regwen & bus.id_valid &
                    (reg_match(idex_q.wsel, bus.id_rs) |
                     (reg_match(idex_q.wsel, bus.id_rt) & rt_used));
   assign raw_mem = bus.mem_regwen & bus.id_valid &
                    (reg_match(bus.mem_wsel, bus.id_rs) |
                     (reg_match(bus.mem_wsel, bus.id_rt) & rt_used));
   assign hazard  = load_use | raw_ex | raw_mem;

   // WB is covered by register-file write-before-read.
   assign fwd_rs     = idex_q.rdat1;
   assign fwd_rt     = idex_q.rdat2;
   assign unused_fwd = ^{bus.mem_result, bus.wb_result, bus.wb_wsel, bus.wb_regwen};
`endif

   always_comb begin
      idex_d = idex_q;
      cnt_d  = cnt_q;
      if (bus.flush) begin
         idex_d = IDEX_BUBBLE;
      end else if (bus.enable && hazard) begin
         idex_d = IDEX_BUBBLE;
         if (cnt_q != '1) begin
            cnt_d = cnt_q + STALL_CNT_W'(1);
         end
      end else if (bus.enable) begin
         idex_d = id_fields;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         idex_q <= IDEX_BUBBLE;
         cnt_q  <= '0;
      end else begin
         idex_q <= idex_d;
         cnt_q  <= cnt_d;
      end
   end

   assign bus.hazard_stall = hazard;
   assign bus.ex_portA     = fwd_rs;
   assign bus.ex_portB     = idex_q.alusrc ? idex_q.imm : fwd_rt;
   assign bus.ex_storedata = fwd_rt;
   assign bus.ex_aluop     = idex_q.aluop;
   assign bus.ex_valid     = idex_q.valid;
   assign bus.ex_regwen    = idex_q.regwen & idex_q.valid;
   assign bus.ex_memren    = idex_q.memren & idex_q.valid;
   assign bus.ex_memwen    = idex_q.memwen & idex_q.valid;
   assign bus.ex_wsel      = idex_q.wsel;
   assign bus.ex_pc        = idex_q.pc;
   assign bus.stall_count  = cnt_q;

endmodule
